// File: rtl/ghost_mover_pkg.sv
// Shared screen geometry, tile grid and FSM encoding for the ghost position-commit stage.
package ghost_mover_pkg;

  localparam int WIDTH        = 640;
  localparam int HEIGHT       = 480;
  localparam int TILE_COL_NUM = 32;
  localparam int TILE_ROW_NUM = 24;
  localparam int XW           = $clog2(WIDTH);
  localparam int YW           = $clog2(HEIGHT);
  localparam int NUM_TILES    = TILE_ROW_NUM * TILE_COL_NUM;
  localparam int TILE_IDX_W   = $clog2(NUM_TILES);

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    GM_WAIT   = 3'd0,
    GM_SAMPLE = 3'd1,
    GM_CHECK  = 3'd2,
    GM_COMMIT = 3'd3,
    GM_HALT   = 3'd4
  } gm_state_t;

  // A tile outside the map reads as a wall so a stray row/col can never be committed.
  function automatic logic wall_at(input logic [NUM_TILES-1:0] walls,
                                   input logic [YW-1:0]        row,
                                   input logic [XW-1:0]        col);
    logic [31:0] idx;
    idx = 32'(row) * 32'(TILE_COL_NUM) + 32'(col);
    if (idx < 32'(NUM_TILES)) return walls[idx[TILE_IDX_W-1:0]];
    return 1'b1;
  endfunction

endpackage

// File: rtl/ghost_mover_if.sv
// Signal bundle between the ghost controller / game logic (master) and ghost_mover (slave).
interface ghost_mover_if;
  import ghost_mover_pkg::*;

  // No valid/ready pair here: next_x/next_y are level inputs sampled on the internal
  // tick, and step_done/blocked are single-cycle result pulses that are never both high.
  logic                 enable;
  logic [XW-1:0]        next_x;
  logic [YW-1:0]        next_y;
  logic [NUM_TILES-1:0] tilemap_walls;
  logic [XW-1:0]        pac_x;
  logic [YW-1:0]        pac_y;
  logic [XW-1:0]        x;
  logic [YW-1:0]        y;
  logic                 step_done;
  logic                 blocked;
  logic                 caught;

  modport master (
    output enable, next_x, next_y, tilemap_walls, pac_x, pac_y,
    input  x, y, step_done, blocked, caught
  );

  modport slave (
    input  enable, next_x, next_y, tilemap_walls, pac_x, pac_y,
    output x, y, step_done, blocked, caught
  );
endinterface

// File: rtl/ghost_mover_tick_divider.sv
// Free-running step pacer: one-cycle tick every DIV enabled cycles; holds while disabled.
module tick_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == CW'(DIV - 1)) ? '0 : count + CW'(1);
    end
  end

  assign tick = enable && (count == CW'(DIV - 1));

endmodule

// File: rtl/ghost_mover.sv
// Ghost position-commit stage: samples the controller's proposal each tick, rejects
// off-screen or walled targets, commits legal moves and latches Pac-Man contact.
module ghost_mover
  import ghost_mover_pkg::*;
#(
  parameter int TICK_DIV = 12500000,
  parameter int START_X  = 20,
  parameter int START_Y  = 320,
  parameter int TILE     = 20,
  parameter int MAX_X    = 620,
  parameter int MAX_Y    = 460
) (
  input  logic               clk,
  input  logic               reset,
  ghost_mover_if.slave       bus,
  output gm_state_t          state
);

  logic          tick;
  logic          count_en;
  logic [XW-1:0] px;
  logic [YW-1:0] py;
  logic [XW-1:0] col;
  logic [YW-1:0] row;
  logic          hit_pac;
  logic          illegal;
  logic          at_pac;

  // Pacing only advances while idle, so an in-flight step never loses a tick slot.
  assign count_en = bus.enable && (state == GM_WAIT);

  tick_divider #(.DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (count_en),
    .tick   (tick)
  );

  // Anything above MAX also covers a controller that subtracted past zero and wrapped.
  assign illegal = (32'(px) > 32'(MAX_X)) ||
                   (32'(py) > 32'(MAX_Y)) ||
                   wall_at(bus.tilemap_walls, row, col);

  assign at_pac = (bus.x == bus.pac_x) && (bus.y == bus.pac_y);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= GM_WAIT;
      bus.x         <= XW'(START_X);
      bus.y         <= YW'(START_Y);
      bus.step_done <= 1'b0;
      bus.blocked   <= 1'b0;
      bus.caught    <= 1'b0;
      px            <= '0;
      py            <= '0;
      col           <= '0;
      row           <= '0;
      hit_pac       <= 1'b0;
    end else begin
      bus.step_done <= 1'b0;
      bus.blocked   <= 1'b0;
      unique case (state)
        GM_WAIT: begin
          if (at_pac) begin
            bus.caught <= 1'b1;
            state      <= GM_HALT;
          end else if (tick) begin
            state <= GM_SAMPLE;
          end
        end
        GM_SAMPLE: begin
          px    <= bus.next_x;
          py    <= bus.next_y;
          col   <= XW'(32'(bus.next_x) / 32'(TILE));
          row   <= YW'(32'(bus.next_y) / 32'(TILE));
          state <= GM_CHECK;
        end
        GM_CHECK: begin
          hit_pac <= (px == bus.pac_x) && (py == bus.pac_y);
          if (illegal) begin
            bus.blocked <= 1'b1;
            state       <= GM_WAIT;
          end else begin
            state <= GM_COMMIT;
          end
        end
        GM_COMMIT: begin
          bus.x         <= px;
          bus.y         <= py;
          bus.step_done <= 1'b1;
          state         <= hit_pac ? GM_HALT : GM_WAIT;
        end
        GM_HALT: begin
          bus.caught <= 1'b1;
        end
        default: state <= GM_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ghost_mover.sv
// Randomised scoreboard bench for ghost_mover with a fast tick divider.
module tb_ghost_mover;
  import ghost_mover_pkg::*;

  localparam int W = 1 + XW + YW;

  logic      clk = 1'b0;
  logic      reset = 1'b0;
  gm_state_t state;

  ghost_mover_if bus ();

  ghost_mover #(.TICK_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .state (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int mx = 20;
  int my = 320;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference rule: on screen and not a wall tile.
  function automatic bit legal_move(input int nx, input int ny, input logic [NUM_TILES-1:0] walls);
    logic [TILE_IDX_W-1:0] bi;
    if (nx > 620 || ny > 460) return 1'b0;
    bi = TILE_IDX_W'((ny / 20) * 32 + (nx / 20));
    return !walls[bi];
  endfunction

  // driver tasks
  task automatic propose(input int nx, input int ny);
    bus.next_x = XW'(nx);
    bus.next_y = YW'(ny);
    if (legal_move(int'(bus.next_x), int'(bus.next_y), bus.tilemap_walls)) begin
      mx = int'(bus.next_x);
      my = int'(bus.next_y);
      exp_q.push_back({1'b1, XW'(mx), YW'(my)});
    end else begin
      exp_q.push_back({1'b0, XW'(mx), YW'(my)});
    end
  endtask

  task automatic wait_pulse(output int lat);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (bus.step_done || bus.blocked) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL pulse_timeout: no step_done/blocked within 60 cycles");
    end
  endtask

  task automatic wait_state(input gm_state_t s);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (state == s) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL state_timeout: state %0d never reached", s);
    end
  endtask

  // monitor
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (bus.step_done || bus.blocked) begin
        check("pulse_exclusive", 32'(bus.step_done && bus.blocked), 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: step_done=%0d blocked=%0d with nothing expected",
                   bus.step_done, bus.blocked);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", 32'(bus.step_done), 32'(e[W-1]));
          check("pos_x", 32'(bus.x), 32'(e[W-2 -: XW]));
          check("pos_y", 32'(bus.y), 32'(e[YW-1:0]));
        end
      end
    end
  end

  // stimulus
  initial begin
    int lat;
    int pulses;
    int mode;

    bus.enable        = 1'b1;
    bus.next_x        = XW'(40);
    bus.next_y        = YW'(320);
    bus.tilemap_walls = '0;
    bus.pac_x         = XW'(1023);
    bus.pac_y         = YW'(511);

    repeat (3) @(posedge clk);
    #1;
    check("rst_x", 32'(bus.x), 32'd20);
    check("rst_y", 32'(bus.y), 32'd320);
    check("rst_caught", 32'(bus.caught), 32'd0);
    check("rst_step_done", 32'(bus.step_done), 32'd0);
    check("rst_blocked", 32'(bus.blocked), 32'd0);
    check("rst_state", 32'(state), 32'(GM_WAIT));

    propose(40, 320);
    reset = 1'b1;
    wait_pulse(lat);
    check("first_step_latency", 32'(lat), 32'd7);
    check("first_step_x", 32'(bus.x), 32'd40);

    // wall at row 16, col 3
    bus.tilemap_walls[16*32 + 3] = 1'b1;
    propose(60, 320);
    wait_pulse(lat);
    check("wall_blocked", 32'(bus.blocked), 32'd1);
    check("wall_no_step", 32'(bus.step_done), 32'd0);
    check("wall_x_held", 32'(bus.x), 32'd40);

    // underflow wrap and far corner
    bus.tilemap_walls = '0;
    propose(0, 320);
    wait_pulse(lat);
    propose(0 - 20, 320);
    wait_pulse(lat);
    check("underflow_blocked", 32'(bus.blocked), 32'd1);
    check("underflow_x_held", 32'(bus.x), 32'd0);
    propose(620, 460);
    wait_pulse(lat);
    check("corner_accept", 32'(bus.step_done), 32'd1);

    // randomised proposals and wall maps
    for (int i = 0; i < 40; i++) begin
      for (int b = 0; b < NUM_TILES; b++) bus.tilemap_walls[b] = ($urandom_range(0, 7) == 0);
      mode = int'($urandom_range(0, 3));
      case (mode)
        0: propose(20 * int'($urandom_range(0, 31)), 20 * int'($urandom_range(0, 23)));
        1: propose(int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)));
        2: propose(mx - 20, my);
        default: propose(mx, my + 20);
      endcase
      wait_pulse(lat);
    end

    // pause right after a pulse: counter must resume from zero
    bus.tilemap_walls = '0;
    bus.enable = 1'b0;
    propose(100, 100);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus.step_done || bus.blocked) pulses++;
    end
    check("pause_no_pulses", 32'(pulses), 32'd0);
    check("pause_state", 32'(state), 32'(GM_WAIT));
    bus.enable = 1'b1;
    wait_pulse(lat);
    check("pause_resume_latency", 32'(lat), 32'd7);

    // enable dropped during CHECK still commits
    propose(120, 100);
    wait_state(GM_CHECK);
    bus.enable = 1'b0;
    wait_pulse(lat);
    check("check_drop_commit", 32'(bus.step_done), 32'd1);
    check("check_drop_x", 32'(bus.x), 32'd120);
    bus.enable = 1'b1;

    // legal move onto Pac-Man
    bus.pac_x = XW'(60);
    bus.pac_y = YW'(320);
    propose(60, 320);
    wait_pulse(lat);
    check("catch_commit", 32'(bus.step_done), 32'd1);
    check("catch_not_yet", 32'(bus.caught), 32'd0);
    @(posedge clk); #1;
    check("caught_next_cycle", 32'(bus.caught), 32'd1);
    check("halt_state", 32'(state), 32'(GM_HALT));
    bus.next_x = XW'(100);
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (bus.step_done || bus.blocked) pulses++;
    end
    check("halt_no_pulses", 32'(pulses), 32'd0);
    check("halt_x_frozen", 32'(bus.x), 32'd60);
    check("halt_caught_sticky", 32'(bus.caught), 32'd1);

    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst2_caught", 32'(bus.caught), 32'd0);
    check("rst2_x", 32'(bus.x), 32'd20);
    check("rst2_y", 32'(bus.y), 32'd320);
    check("rst2_state", 32'(state), 32'(GM_WAIT));
    mx = 20;
    my = 320;

    // reset landing on the COMMIT cycle
    bus.pac_x  = XW'(1023);
    bus.pac_y  = YW'(511);
    bus.next_x = XW'(40);
    bus.next_y = YW'(320);
    reset = 1'b1;
    wait_state(GM_COMMIT);
    reset = 1'b0;
    @(posedge clk); #1;
    check("midcommit_no_step", 32'(bus.step_done), 32'd0);
    check("midcommit_x", 32'(bus.x), 32'd20);
    check("midcommit_y", 32'(bus.y), 32'd320);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
